// File: rtl/mtr_drv.sv
// rtl/mtr_drv.sv - dual H-bridge PWM driver: double-buffered duty, deadtime insertion.
// Optional per-period duty slew limiting when MTR_DRV_SLEW_EN is defined.
module mtr_drv #(
  parameter int DEADTIME  = 32,
  parameter int SLEW_STEP = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  output logic               lft_hi,
  output logic               lft_lo,
  output logic               rght_hi,
  output logic               rght_lo,
  output logic               prd_strb
);

  localparam logic [5:0] DT = 6'(DEADTIME);
`ifdef MTR_DRV_SLEW_EN
  localparam logic [10:0] STEP = 11'(SLEW_STEP);
`endif

  if (DEADTIME < 1 || DEADTIME > 63 || SLEW_STEP < 1 || SLEW_STEP > 1023) begin : g_bad_param
    $error("mtr_drv: DEADTIME or SLEW_STEP out of range");
  end

  logic [10:0]      cnt_q, cnt_d;
  logic             strb_q, strb_d;
  logic [1:0][11:0] spd;
  logic [1:0][10:0] tgt;
  logic [1:0][10:0] duty_q, duty_d;
  logic [1:0][5:0]  dt_q, dt_d;
  logic [1:0]       pwm_q, pwm_d;
  logic [1:0]       hi_q, hi_d;
  logic [1:0]       lo_q, lo_d;

  assign spd = {rght_spd, lft_spd};

  // Offset-binary duty: -1024 -> 000, 0 -> 400, +1023 -> 7FF.
  function automatic logic [10:0] duty_tgt(input logic [11:0] s);
    logic signed [11:0] v;
    v = $signed(s);
    if (v > 12'sd1023) begin
      v = 12'sd1023;
    end else if (v < -12'sd1024) begin
      v = -12'sd1024;
    end
    return 11'h400 + v[10:0];
  endfunction

  always_comb begin
    cnt_d  = cnt_q + 11'd1;
    strb_d = (cnt_q == 11'h7FE);
    for (int i = 0; i < 2; i++) begin
      tgt[i]    = duty_tgt(spd[i]);
      duty_d[i] = duty_q[i];
      if (cnt_q == 11'h7FF) begin
`ifdef MTR_DRV_SLEW_EN
        if (tgt[i] > duty_q[i]) begin
          duty_d[i] = ((tgt[i] - duty_q[i]) > STEP) ? duty_q[i] + STEP : tgt[i];
        end else begin
          duty_d[i] = ((duty_q[i] - tgt[i]) > STEP) ? duty_q[i] - STEP : tgt[i];
        end
`else
        duty_d[i] = tgt[i];
`endif
      end
      pwm_d[i] = (cnt_q < duty_q[i]);
      // Any raw edge drops both gates on the same clock and restarts the stability count.
      if (pwm_d[i] != pwm_q[i]) begin
        dt_d[i] = '0;
      end else if (dt_q[i] == DT) begin
        dt_d[i] = dt_q[i];
      end else begin
        dt_d[i] = dt_q[i] + 6'd1;
      end
      hi_d[i] = (dt_d[i] == DT) &  pwm_q[i];
      lo_d[i] = (dt_d[i] == DT) & ~pwm_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      strb_q <= 1'b0;
      duty_q <= {2{11'h400}};
      dt_q   <= '0;
      pwm_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      strb_q <= strb_d;
      duty_q <= duty_d;
      dt_q   <= dt_d;
      pwm_q  <= pwm_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign lft_hi   = hi_q[0];
  assign lft_lo   = lo_q[0];
  assign rght_hi  = hi_q[1];
  assign rght_lo  = lo_q[1];
  assign prd_strb = strb_q;

endmodule
